// File: rtl/ctrl_seq_pkg.sv
// Shared types for the instruction sequencer: datapath control enums,
// sequencer states, opcode classes and instruction-byte field positions.
package ctrl_seq_pkg;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_ctrl_op_e;

    typedef enum logic [2:0] {
        AR_NOP    = 3'd0,
        AR_INC    = 3'd1,
        AR_LD_LO  = 3'd2,
        AR_LD_HI  = 3'd3,
        AR_LD_BUS = 3'd4,
        AR_DEC    = 3'd5,
        AR_CLR    = 3'd6,
        AR_HOLD   = 3'd7
    } addr_register_op_e;

    typedef enum logic {
        PC  = 1'b0,
        MAR = 1'b1
    } addr_sel_e;

    typedef enum logic [2:0] {
        THR = 3'd0,
        ADD = 3'd1,
        SUB = 3'd2,
        AND = 3'd3,
        OR  = 3'd4,
        XOR = 3'd5,
        NOT = 3'd6,
        SHL = 3'd7
    } alu_op_e;

    typedef enum logic {
        REG_NOP   = 1'b0,
        REG_WRITE = 1'b1
    } registers_op_e;

    typedef enum logic [1:0] {
        REG_A = 2'd0,
        REG_B = 2'd1,
        REG_C = 2'd2,
        REG_D = 2'd3
    } register_sel_e;

    typedef enum logic {
        MUX_ALU = 1'b0,
        MUX_MEM = 1'b1
    } mux_sel_e;

    typedef struct packed {
        logic carry;
        logic zero;
    } alu_flag_t;

    typedef enum logic [1:0] {
        OPC_NOP = 2'b00,
        OPC_ALU = 2'b01,
        OPC_LDX = 2'b10,
        OPC_JMP = 2'b11
    } opcode_e;

    typedef enum logic [3:0] {
        ST_FETCH      = 4'd0,
        ST_DECODE     = 4'd1,
        ST_ALU_OP     = 4'd2,
        ST_LDX_READ   = 4'd3,
        ST_LDX_WRITE  = 4'd4,
        ST_LDI_WAIT   = 4'd5,
        ST_JMP_WAIT   = 4'd6,
        ST_SKIP_PARAM = 4'd7,
        ST_INC_PC     = 4'd8,
        ST_HALT       = 4'd9,
        ST_ERROR      = 4'd10
    } ctrl_state_e;

    // Bit positions inside the top byte of the bus (opcode word)
    localparam int unsigned F_OPC_HI    = 7;
    localparam int unsigned F_OPC_LO    = 6;
    localparam int unsigned F_MODE      = 5;  // NOP: halt, LDX: load, JMP: needs carry
    localparam int unsigned F_JMP_Z     = 4;  // JMP: needs zero
    localparam int unsigned F_ALU_HI    = 5;
    localparam int unsigned F_ALU_LO    = 3;
    localparam int unsigned F_ARS1_HI   = 2;
    localparam int unsigned F_ARS1_LO   = 1;
    localparam int unsigned F_LREG_HI   = 4;
    localparam int unsigned F_LREG_LO   = 3;
    localparam int unsigned F_LDI       = 2;
    localparam int unsigned F_JREG_HI   = 3;
    localparam int unsigned F_JREG_LO   = 2;
    localparam int unsigned F_JASEL     = 1;

    // Bit positions inside the top byte of the parameter word
    localparam int unsigned P_RS2_HI    = 7;
    localparam int unsigned P_RS2_LO    = 6;
    localparam int unsigned P_RIN_HI    = 5;
    localparam int unsigned P_RIN_LO    = 4;
    localparam int unsigned P_AR_HI     = 7;
    localparam int unsigned P_AR_LO     = 5;

    // A condition bit that is clear does not constrain the jump
    function automatic logic jmp_taken(input logic need_c, input logic need_z,
                                       input alu_flag_t flags);
        return (!need_c || flags.carry) && (!need_z || flags.zero);
    endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// Sequencer <-> datapath bundle. master = sequencer, slave = datapath/memory side.
interface ctrl_seq_if #(
    parameter int unsigned DATA_BUS_WIDTH = 8
) ();
    import ctrl_seq_pkg::*;

    logic [DATA_BUS_WIDTH-1:0] bus_data_in;
    logic                      mem_op_done;
    alu_flag_t                 alu_flags;
    logic                      run;

    mem_ctrl_op_e              mem_ctrl_op;
    addr_register_op_e         addr_reg_op;
    addr_sel_e                 addr_sel;
    alu_op_e                   alu_op;
    registers_op_e             reg_op;
    register_sel_e             reg_sel_in;
    register_sel_e             reg_sel_1;
    register_sel_e             reg_sel_2;
    mux_sel_e                  mux_sel;
    logic                      halted;
    logic                      mem_error;

    modport master (
        input  bus_data_in, mem_op_done, alu_flags, run,
        output mem_ctrl_op, addr_reg_op, addr_sel, alu_op, reg_op,
               reg_sel_in, reg_sel_1, reg_sel_2, mux_sel, halted, mem_error
    );

    modport slave (
        output bus_data_in, mem_op_done, alu_flags, run,
        input  mem_ctrl_op, addr_reg_op, addr_sel, alu_op, reg_op,
               reg_sel_in, reg_sel_1, reg_sel_2, mux_sel, halted, mem_error
    );
endinterface

// File: rtl/ctrl_seq_timeout.sv
// Clearable saturating wait counter; expired once MEM_TIMEOUT stalled cycles have accumulated.
module ctrl_timeout #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int unsigned CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] r_count;

    // Count stalled cycles, hold at the limit, clear on request
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = (r_count == LIMIT);
endmodule

// File: rtl/ctrl_seq.sv
// Instruction sequencer: fetch/decode and registered datapath control.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// ST_FETCH       | issue opcode read at PC
// ST_DECODE      | wait for opcode, decode top byte
// ST_ALU_OP      | read ALU parameter word, then write result register
// ST_LDX_READ    | memory read at MAR into reg_sel_in
// ST_LDX_WRITE   | memory write at MAR from reg_sel_1 (ALU passthrough)
// ST_LDI_WAIT    | read immediate at PC into reg_sel_in
// ST_JMP_WAIT    | read jump parameter, load address register
// ST_SKIP_PARAM  | not-taken jump: step PC over the parameter word
// ST_INC_PC      | step PC past the last consumed word
// ST_HALT        | idle until run
// ST_ERROR       | memory handshake timed out, wait for reset
module ctrl_seq #(
    parameter int unsigned DATA_BUS_WIDTH = 8,
    parameter int unsigned MEM_TIMEOUT    = 15
) (
    input  logic       i_clock,
    input  logic       i_reset,
    ctrl_seq_if.master io_ctrl
);
    import ctrl_seq_pkg::*;

    ctrl_state_e       r_state;
    mem_ctrl_op_e      r_mem_ctrl_op;
    addr_register_op_e r_addr_reg_op;
    addr_sel_e         r_addr_sel;
    alu_op_e           r_alu_op;
    registers_op_e     r_reg_op;
    register_sel_e     r_reg_sel_in;
    register_sel_e     r_reg_sel_1;
    register_sel_e     r_reg_sel_2;
    mux_sel_e          r_mux_sel;
    addr_sel_e         r_jmp_addr_sel;
    logic              r_halted;
    logic              r_mem_error;

    // Bit 0 of the top byte carries no meaning in any instruction format
    logic [7:1] w_b;
    logic       w_done;
    logic       w_wait;
    logic       w_stall;
    logic       w_expired;

    assign w_b     = io_ctrl.bus_data_in[DATA_BUS_WIDTH-1 -: 7];
    assign w_done  = io_ctrl.mem_op_done;
    assign w_wait  = r_state inside {ST_DECODE, ST_ALU_OP, ST_LDI_WAIT,
                                     ST_LDX_READ, ST_LDX_WRITE, ST_JMP_WAIT};
    assign w_stall = w_wait && !w_done;

    // Any non-stalled cycle clears, so every wait state starts counting from zero
    ctrl_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (!w_stall),
        .i_enable  (w_stall),
        .o_expired (w_expired)
    );

    // Sequencer FSM; every output reverts to its idle value unless the state drives it
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_FETCH;
            r_mem_ctrl_op  <= MEM_NOP;
            r_addr_reg_op  <= AR_NOP;
            r_addr_sel     <= PC;
            r_alu_op       <= THR;
            r_reg_op       <= REG_NOP;
            r_reg_sel_in   <= REG_A;
            r_reg_sel_1    <= REG_A;
            r_reg_sel_2    <= REG_A;
            r_mux_sel      <= MUX_ALU;
            r_jmp_addr_sel <= PC;
            r_halted       <= 1'b0;
            r_mem_error    <= 1'b0;
        end else begin
            r_mem_ctrl_op <= MEM_NOP;
            r_addr_reg_op <= AR_NOP;
            r_addr_sel    <= PC;
            r_alu_op      <= THR;
            r_reg_op      <= REG_NOP;
            r_reg_sel_in  <= REG_A;
            r_reg_sel_1   <= REG_A;
            r_reg_sel_2   <= REG_A;
            r_mux_sel     <= MUX_ALU;
            r_halted      <= 1'b0;

            // A done arriving on the limit cycle is not a stall, so it wins
            if (w_stall && w_expired) begin
                r_state     <= ST_ERROR;
                r_mem_error <= 1'b1;
            end else begin
                case (r_state)
                    ST_FETCH: begin
                        r_mem_ctrl_op <= MEM_READ;
                        r_mux_sel     <= MUX_MEM;
                        r_state       <= ST_DECODE;
                    end
                    ST_DECODE: begin
                        if (!w_done) begin
                            r_mem_ctrl_op <= MEM_READ;
                            r_mux_sel     <= MUX_MEM;
                        end else begin
                            case (opcode_e'(w_b[F_OPC_HI:F_OPC_LO]))
                                OPC_NOP: begin
                                    r_halted <= w_b[F_MODE];
                                    r_state  <= w_b[F_MODE] ? ST_HALT : ST_INC_PC;
                                end
                                OPC_ALU: begin
                                    r_alu_op      <= alu_op_e'(w_b[F_ALU_HI:F_ALU_LO]);
                                    r_reg_sel_1   <= register_sel_e'(w_b[F_ARS1_HI:F_ARS1_LO]);
                                    r_addr_reg_op <= AR_INC;
                                    r_state       <= ST_ALU_OP;
                                end
                                OPC_LDX: begin
                                    if (w_b[F_MODE] && w_b[F_LDI]) begin
                                        r_reg_sel_in  <= register_sel_e'(w_b[F_LREG_HI:F_LREG_LO]);
                                        r_addr_reg_op <= AR_INC;
                                        r_state       <= ST_LDI_WAIT;
                                    end else if (w_b[F_MODE]) begin
                                        r_mem_ctrl_op <= MEM_READ;
                                        r_addr_sel    <= MAR;
                                        r_reg_sel_in  <= register_sel_e'(w_b[F_LREG_HI:F_LREG_LO]);
                                        r_state       <= ST_LDX_READ;
                                    end else begin
                                        r_reg_sel_1   <= register_sel_e'(w_b[F_LREG_HI:F_LREG_LO]);
                                        r_mem_ctrl_op <= MEM_WRITE;
                                        r_addr_sel    <= MAR;
                                        r_state       <= ST_LDX_WRITE;
                                    end
                                end
                                OPC_JMP: begin
                                    r_addr_reg_op <= AR_INC;
                                    if (jmp_taken(w_b[F_MODE], w_b[F_JMP_Z], io_ctrl.alu_flags)) begin
                                        r_reg_sel_1    <= register_sel_e'(w_b[F_JREG_HI:F_JREG_LO]);
                                        r_jmp_addr_sel <= addr_sel_e'(w_b[F_JASEL]);
                                        r_state        <= ST_JMP_WAIT;
                                    end else begin
                                        r_state        <= ST_SKIP_PARAM;
                                    end
                                end
                                default: r_state <= ST_FETCH;
                            endcase
                        end
                    end
                    ST_ALU_OP: begin
                        r_alu_op    <= r_alu_op;
                        r_reg_sel_1 <= r_reg_sel_1;
                        if (!w_done) begin
                            r_mem_ctrl_op <= MEM_READ;
                        end else begin
                            r_reg_sel_2 <= register_sel_e'(w_b[P_RS2_HI:P_RS2_LO]);
                            r_reg_sel_in <= register_sel_e'(w_b[P_RIN_HI:P_RIN_LO]);
                            r_reg_op    <= REG_WRITE;
                            r_state     <= ST_INC_PC;
                        end
                    end
                    ST_LDI_WAIT: begin
                        r_reg_sel_in <= r_reg_sel_in;
                        r_mux_sel    <= MUX_MEM;
                        if (!w_done) begin
                            r_mem_ctrl_op <= MEM_READ;
                        end else begin
                            r_reg_op <= REG_WRITE;
                            r_state  <= ST_INC_PC;
                        end
                    end
                    ST_LDX_READ: begin
                        r_reg_sel_in <= r_reg_sel_in;
                        r_addr_sel   <= MAR;
                        if (!w_done) begin
                            r_mem_ctrl_op <= MEM_READ;
                        end else begin
                            r_reg_op <= REG_WRITE;
                            r_state  <= ST_INC_PC;
                        end
                    end
                    ST_LDX_WRITE: begin
                        if (!w_done) begin
                            r_reg_sel_1   <= r_reg_sel_1;
                            r_mem_ctrl_op <= MEM_WRITE;
                            r_addr_sel    <= MAR;
                        end else begin
                            r_state <= ST_INC_PC;
                        end
                    end
                    ST_JMP_WAIT: begin
                        r_reg_sel_1 <= r_reg_sel_1;
                        if (!w_done) begin
                            r_mem_ctrl_op <= MEM_READ;
                        end else begin
                            r_addr_sel    <= r_jmp_addr_sel;
                            r_addr_reg_op <= addr_register_op_e'(w_b[P_AR_HI:P_AR_LO]);
                            r_state       <= ST_INC_PC;
                        end
                    end
                    // Opcode step came from DECODE; this step covers the parameter word
                    ST_SKIP_PARAM: begin
                        r_addr_reg_op <= AR_INC;
                        r_state       <= ST_FETCH;
                    end
                    ST_INC_PC: begin
                        r_addr_reg_op <= AR_INC;
                        r_state       <= ST_FETCH;
                    end
                    ST_HALT: begin
                        if (io_ctrl.run) begin
                            r_state <= ST_INC_PC;
                        end else begin
                            r_halted <= 1'b1;
                        end
                    end
                    ST_ERROR: begin
                        r_state <= ST_ERROR;
                    end
                    default: r_state <= ST_FETCH;
                endcase
            end
        end
    end

    assign io_ctrl.mem_ctrl_op = r_mem_ctrl_op;
    assign io_ctrl.addr_reg_op = r_addr_reg_op;
    assign io_ctrl.addr_sel    = r_addr_sel;
    assign io_ctrl.alu_op      = r_alu_op;
    assign io_ctrl.reg_op      = r_reg_op;
    assign io_ctrl.reg_sel_in  = r_reg_sel_in;
    assign io_ctrl.reg_sel_1   = r_reg_sel_1;
    assign io_ctrl.reg_sel_2   = r_reg_sel_2;
    assign io_ctrl.mux_sel     = r_mux_sel;
    assign io_ctrl.halted      = r_halted;
    assign io_ctrl.mem_error   = r_mem_error;
endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: per-instruction expected control traces built from the
// instruction semantics, directed cases plus randomized instruction streams.
module tb_ctrl_seq;
    import ctrl_seq_pkg::*;

    localparam int W   = 16;
    localparam int TMO = 3;

    typedef struct packed {
        mem_ctrl_op_e      mem;
        addr_register_op_e ar;
        addr_sel_e         asel;
        alu_op_e           alu;
        registers_op_e     rop;
        register_sel_e     rin;
        register_sel_e     r1;
        register_sel_e     r2;
        mux_sel_e          mux;
        logic              halted;
        logic              err;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    ctrl_seq_if #(.DATA_BUS_WIDTH(W)) u_if ();

    ctrl_seq #(.DATA_BUS_WIDTH(W), .MEM_TIMEOUT(TMO)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .io_ctrl (u_if)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic snap_t idle_s();
        snap_t s;
        s.mem = MEM_NOP;  s.ar = AR_NOP;   s.asel = PC;      s.alu = THR;
        s.rop = REG_NOP;  s.rin = REG_A;   s.r1 = REG_A;     s.r2 = REG_A;
        s.mux = MUX_ALU;  s.halted = 1'b0; s.err = 1'b0;
        return s;
    endfunction

    function automatic snap_t err_s();
        snap_t s;
        s = idle_s();
        s.err = 1'b1;
        return s;
    endfunction

    function automatic snap_t obs();
        snap_t s;
        s.mem = u_if.mem_ctrl_op;  s.ar = u_if.addr_reg_op; s.asel = u_if.addr_sel;
        s.alu = u_if.alu_op;       s.rop = u_if.reg_op;     s.rin = u_if.reg_sel_in;
        s.r1 = u_if.reg_sel_1;     s.r2 = u_if.reg_sel_2;   s.mux = u_if.mux_sel;
        s.halted = u_if.halted;    s.err = u_if.mem_error;
        return s;
    endfunction

    // Apply inputs for one cycle, clock once, compare the registered outputs
    task automatic cyc(input string tag, input logic [7:0] top, input logic done,
                       input logic run_i, input logic c, input logic z, input snap_t exp);
        snap_t got;
        u_if.bus_data_in = {top, 8'($urandom)};
        u_if.mem_op_done = done;
        u_if.run         = run_i;
        u_if.alu_flags   = '{carry: c, zero: z};
        @(posedge clk);
        #1;
        got = obs();
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // lat stalled cycles; more than TMO of them must end in the error state
    task automatic wait_phase(input string tag, input snap_t look, input int lat, output bit ok);
        ok = 1'b1;
        for (int k = 0; k < lat; k++) begin
            if (k < TMO) begin
                cyc(tag, 8'($urandom), 1'b0, rb(), rb(), rb(), look);
            end else begin
                cyc({tag, "_timeout"}, 8'($urandom), 1'b0, rb(), rb(), rb(), err_s());
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic apply_reset(input string tag);
        snap_t got;
        rst = 1'b1;
        u_if.mem_op_done = 1'b0;
        u_if.run = 1'b0;
        #2;
        got = obs();
        checks++;
        assert (got === idle_s()) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, idle_s());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One full instruction from FETCH back to the next FETCH
    task automatic exec_instr(input logic [7:0] op, input logic [7:0] prm, input logic c,
                              input logic z, input int lat1, input int lat2, input int hold,
                              output bit errored);
        snap_t e, w, d;
        bit    ok;
        logic  taken;
        errored = 1'b0;
        taken   = (!op[5] || c) && (!op[4] || z);

        e = idle_s();
        e.mem = MEM_READ;
        e.mux = MUX_MEM;
        cyc("fetch", 8'($urandom), rb(), rb(), rb(), rb(), e);
        wait_phase("decode_wait", e, lat1, ok);
        if (!ok) begin
            errored = 1'b1;
            return;
        end

        e = idle_s();
        case (op[7:6])
            2'b00: e.halted = op[5];
            2'b01: begin
                e.alu = alu_op_e'(op[5:3]);
                e.r1  = register_sel_e'(op[2:1]);
                e.ar  = AR_INC;
            end
            2'b10: begin
                if (op[5] && op[2]) begin
                    e.rin = register_sel_e'(op[4:3]);
                    e.ar  = AR_INC;
                end else if (op[5]) begin
                    e.mem = MEM_READ;  e.asel = MAR;  e.rin = register_sel_e'(op[4:3]);
                end else begin
                    e.mem = MEM_WRITE; e.asel = MAR;  e.r1 = register_sel_e'(op[4:3]);
                end
            end
            default: begin
                e.ar = AR_INC;
                if (taken) e.r1 = register_sel_e'(op[3:2]);
            end
        endcase
        cyc("decode", op, 1'b1, rb(), c, z, e);

        w = idle_s();
        d = idle_s();
        ok = 1'b1;
        case (op[7:6])
            2'b00: begin
                if (op[5]) begin
                    w.halted = 1'b1;
                    for (int k = 0; k < hold; k++)
                        cyc("halt_hold", 8'($urandom), rb(), 1'b0, rb(), rb(), w);
                    cyc("halt_run", 8'($urandom), rb(), 1'b1, rb(), rb(), idle_s());
                end
            end
            2'b01: begin
                w.mem = MEM_READ; w.alu = e.alu; w.r1 = e.r1;
                wait_phase("alu_wait", w, lat2, ok);
                d.alu = e.alu; d.r1 = e.r1; d.rop = REG_WRITE;
                d.r2  = register_sel_e'(prm[7:6]);
                d.rin = register_sel_e'(prm[5:4]);
                if (ok) cyc("alu_done", prm, 1'b1, rb(), rb(), rb(), d);
            end
            2'b10: begin
                if (op[5] && op[2]) begin
                    w.mem = MEM_READ; w.mux = MUX_MEM; w.rin = e.rin;
                    d.rop = REG_WRITE; d.mux = MUX_MEM; d.rin = e.rin;
                end else if (op[5]) begin
                    w = e;
                    d.rop = REG_WRITE; d.asel = MAR; d.rin = e.rin;
                end else begin
                    w = e;
                end
                wait_phase("ldx_wait", w, lat2, ok);
                if (ok) cyc("ldx_done", prm, 1'b1, rb(), rb(), rb(), d);
            end
            default: begin
                if (taken) begin
                    w.mem = MEM_READ; w.r1 = e.r1;
                    wait_phase("jmp_wait", w, lat2, ok);
                    d.r1   = e.r1;
                    d.asel = op[1] ? MAR : PC;
                    d.ar   = addr_register_op_e'(prm[7:5]);
                    if (ok) cyc("jmp_done", prm, 1'b1, rb(), rb(), rb(), d);
                end
            end
        endcase
        if (!ok) begin
            errored = 1'b1;
            return;
        end

        // Final PC step; the parameter stays on the bus for the write-back cycle
        e = idle_s();
        e.ar = AR_INC;
        cyc("inc_pc", prm, rb(), rb(), rb(), rb(), e);
    endtask

    initial begin
        bit          er;
        logic [7:0]  op, prm;
        snap_t       e;

        u_if.bus_data_in = '0;
        u_if.mem_op_done = 1'b0;
        u_if.run         = 1'b0;
        u_if.alu_flags   = '{carry: 1'b0, zero: 1'b0};
        #1;
        apply_reset("reset_values");

        // ALU with parameter, done after two stalled cycles
        exec_instr(8'b01_010_01_0, 8'b10_11_0000, 1'b0, 1'b0, 0, 2, 0, er);
        // Immediate load of 0x5A into register B
        exec_instr(8'b10_1_01_1_00, 8'h5A, 1'b0, 1'b0, 1, 0, 0, er);
        // Conditional jump needing carry: not taken, then taken
        exec_instr(8'b11_1_0_10_1_0, 8'b101_00000, 1'b0, 1'b0, 0, 1, 0, er);
        exec_instr(8'b11_1_0_10_1_0, 8'b101_00000, 1'b1, 1'b0, 0, 1, 0, er);
        // HALT held for 20 cycles then resumed
        exec_instr(8'b00_1_00000, 8'h00, 1'b0, 1'b0, 0, 0, 20, er);
        // Plain NOP, LDX read, LDX write
        exec_instr(8'b00_0_11111, 8'hFF, 1'b1, 1'b1, 2, 0, 0, er);
        exec_instr(8'b10_1_11_0_11, 8'h00, 1'b0, 1'b0, 0, 3, 0, er);
        exec_instr(8'b10_0_10_1_01, 8'h00, 1'b0, 1'b0, 1, 2, 0, er);

        // Timeout boundary in DECODE: done on the 3rd cycle and on the limit cycle
        exec_instr(8'h00, 8'h00, 1'b0, 1'b0, TMO - 1, 0, 0, er);
        exec_instr(8'h00, 8'h00, 1'b0, 1'b0, TMO, 0, 0, er);
        // Done never arrives: error is raised and sticks through done/run
        exec_instr(8'h00, 8'h00, 1'b0, 1'b0, TMO + 1, 0, 0, er);
        for (int k = 0; k < 5; k++)
            cyc("error_sticky", 8'($urandom), 1'b1, 1'b1, rb(), rb(), err_s());
        apply_reset("reset_clears_error");
        // Timeout in the ALU parameter wait
        exec_instr(8'b01_001_11_0, 8'h40, 1'b0, 1'b0, 0, TMO + 1, 0, er);
        cyc("error_sticky_alu", 8'($urandom), 1'b1, 1'b1, rb(), rb(), err_s());
        apply_reset("reset_after_alu_error");

        // Reset while an opcode read is in flight
        e = idle_s();
        e.mem = MEM_READ;
        e.mux = MUX_MEM;
        cyc("fetch_pre_reset", 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, e);
        cyc("decode_pre_reset", 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, e);
        apply_reset("reset_mid_decode");
        exec_instr(8'b00_0_00000, 8'h00, 1'b0, 1'b0, 0, 0, 0, er);

        // Randomized instruction stream, occasional parameter-wait timeouts
        for (int n = 0; n < 60; n++) begin
            op  = 8'($urandom);
            prm = 8'($urandom);
            exec_instr(op, prm, rb(), rb(), $urandom_range(0, TMO),
                       ($urandom_range(0, 9) == 0) ? TMO + 1 : $urandom_range(0, TMO),
                       $urandom_range(0, 4), er);
            if (er) begin
                cyc("rand_error_hold", 8'($urandom), rb(), rb(), rb(), rb(), err_s());
                apply_reset("rand_reset");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
